// File: rtl/hs_bridge_pkg.sv
// Shared types and constants for the valid/ready -> req/ack bridge.
// Holds the FSM state enum, the handshake mode encodings and a width helper.
package hs_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam int unsigned MODE_4PH = 0;
  localparam int unsigned MODE_2PH = 1;

  // Ceiling log2 usable in constant expressions (port widths).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Show-ahead synchronous FIFO with a registered full flag and occupancy count.
// A written word becomes visible to the read side one edge after the write.
module bridge_fifo
  import hs_bridge_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wen,
  input  logic                          ren,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic                          full,
  output logic                          empty,
  output logic [clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wptr_vis_q;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          wr, rd;

  assign wr = wen & ~full_q;
  assign rd = ren & ~empty;

  // Occupancy and pointer bookkeeping; write and pop together cancel out.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr) wptr_d = wptr_q + PW'(1);
    if (rd) rptr_d = rptr_q + PW'(1);
    case ({wr, rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      wptr_vis_q <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      wptr_vis_q <= wptr_q;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= din;
  end

  // Read side compares against the delayed write pointer so it never sees an unwritten slot.
  assign empty = (rptr_q == wptr_vis_q);
  assign dout  = mem_q[rptr_q[AW-1:0]];
  assign full  = full_q;
  assign level = level_q;

endmodule

// File: rtl/vr_reqack_bridge.sv
// Valid/ready producer port buffered through a FIFO and delivered over a req/ack
// handshake (4-phase or 2-phase), with the consumer ack synchronised into clk.
module vr_reqack_bridge
  import hs_bridge_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DW-1:0]               data_i,
  input  logic                        valid,
  output logic                        ready,
  output logic [DW-1:0]               data_o,
  output logic                        req,
  input  logic                        ack,
  output logic [clog2(DEPTH+1)-1:0]   level,
  output logic                        busy
);

  localparam bit TWO_PHASE = (MODE == MODE_2PH);

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic          pop;

  logic [DW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  bridge_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .wen   (valid),
    .ren   (pop),
    .din   (data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Ack synchroniser; the FSM only ever looks at ack_s.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ack_sync_q <= '0;
    else       ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Handshake FSM: one pop per transfer, data_o held until completion.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_dout;
          req_d   = TWO_PHASE ? ~req_q : 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (TWO_PHASE) begin
          if (ack_s == req_q) state_d = IDLE;
        end else if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        // Release done: start the next queued word on this same edge.
        if (!ack_s) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_dout;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign req    = req_q;
  assign data_o = data_q;
  assign ready  = ~fifo_full;
  assign busy   = (state_q != IDLE) || (level != '0);

endmodule

// File: tb/tb_vr_reqack_bridge.sv
// Directed bench for vr_reqack_bridge: one 4-phase and one 2-phase instance,
// driven and sampled 1 time unit after each rising edge.
module tb_vr_reqack_bridge;

  logic       clk;
  logic       rstn;

  logic [7:0] data_i0, data_o0, data_i1, data_o1;
  logic       valid0, ready0, req0, ack0, busy0;
  logic       valid1, ready1, req1, ack1, busy1;
  logic [2:0] level0, level1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] w3 [3];
  logic       t3 [3];

  vr_reqack_bridge #(.DW(8), .DEPTH(4), .MODE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rstn(rstn), .data_i(data_i0), .valid(valid0), .ready(ready0),
    .data_o(data_o0), .req(req0), .ack(ack0), .level(level0), .busy(busy0)
  );

  vr_reqack_bridge #(.DW(8), .DEPTH(4), .MODE(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rstn(rstn), .data_i(data_i1), .valid(valid1), .ready(ready1),
    .data_o(data_o1), .req(req1), .ack(ack1), .level(level1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input bit sel, input logic v, input string tag);
    for (int i = 0; i < 64; i++) begin
      if ((sel ? req1 : req0) === v) break;
      step();
    end
    chk(tag, sel ? req1 : req0, v);
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    for (int i = 0; i < 128; i++) begin
      if ((sel ? busy1 : busy0) === 1'b0) break;
      step();
    end
    chk(tag, sel ? busy1 : busy0, 1'b0);
  endtask

  // Full 4-phase consumer transaction on dut0, checking the delivered word.
  task automatic deliver0(input logic [7:0] w, input string tag);
    wait_req(1'b0, 1'b1, {tag, " req_hi"});
    chk({tag, " data"}, data_o0, w);
    ack0 = 1'b1;
    wait_req(1'b0, 1'b0, {tag, " req_lo"});
    chk({tag, " data_hold"}, data_o0, w);
    ack0 = 1'b0;
  endtask

  // Complete the current dut0 transfer and stop on the edge REL sees ack_s=0.
  task automatic ack_cycle0(input string tag);
    ack0 = 1'b1;
    wait_req(1'b0, 1'b0, tag);
    ack0 = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    w3[0] = 8'h10; w3[1] = 8'h20; w3[2] = 8'h30;
    t3[0] = 1'b1;  t3[1] = 1'b0;  t3[2] = 1'b1;
    rstn = 1'b0;
    valid0 = 1'b0; data_i0 = 8'h00; ack0 = 1'b0;
    valid1 = 1'b0; data_i1 = 8'h00; ack1 = 1'b0;
    step(); step();
    chk("rst req", req0, 1'b0);
    chk("rst data_o", data_o0, 8'h00);
    chk("rst level", level0, 3'd0);
    chk("rst ready", ready0, 1'b1);
    chk("rst busy", busy0, 1'b0);
    chk("rst req m1", req1, 1'b0);
    rstn = 1'b1;
    step();

    // 1: single word, 4-phase
    valid0 = 1'b1; data_i0 = 8'hA5;
    step();
    valid0 = 1'b0;
    chk("t1 level after accept", level0, 3'd1);
    chk("t1 req +1", req0, 1'b0);
    step();
    chk("t1 req +1 edge", req0, 1'b0);
    step();
    chk("t1 req +2 edges", req0, 1'b1);
    chk("t1 data_o", data_o0, 8'hA5);
    chk("t1 level popped", level0, 3'd0);
    step(); step();
    ack0 = 1'b1;
    step();
    chk("t1 req hold a", req0, 1'b1);
    step();
    chk("t1 req hold b", req0, 1'b1);
    step();
    chk("t1 req drop", req0, 1'b0);
    ack0 = 1'b0;
    step(); step();
    chk("t1 busy in REL", busy0, 1'b1);
    step();
    chk("t1 busy done", busy0, 1'b0);
    chk("t1 data_o kept", data_o0, 8'hA5);

    // 2: ack held low, five words, FIFO fills
    for (int i = 1; i <= 5; i++) begin
      valid0 = 1'b1; data_i0 = 8'(i);
      step();
    end
    chk("t2 level full", level0, 3'd4);
    chk("t2 ready low", ready0, 1'b0);
    chk("t2 first word out", data_o0, 8'h01);
    data_i0 = 8'h06;
    step();
    valid0 = 1'b0;
    chk("t2 no write at full", level0, 3'd4);
    for (int i = 1; i <= 5; i++) deliver0(8'(i), $sformatf("t2 w%0d", i));
    wait_idle(1'b0, "t2 idle");
    chk("t2 level empty", level0, 3'd0);

    // 3: 2-phase mode
    valid1 = 1'b1; data_i1 = 8'h10; step();
    data_i1 = 8'h20; step();
    data_i1 = 8'h30; step();
    valid1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_req(1'b1, t3[k], $sformatf("t3 req toggle %0d", k));
      chk($sformatf("t3 data %0d", k), data_o1, w3[k]);
      step(); step();
      chk($sformatf("t3 data stable %0d", k), data_o1, w3[k]);
      ack1 = t3[k];
      step(); step(); step();
      chk($sformatf("t3 data at done %0d", k), data_o1, w3[k]);
      chk($sformatf("t3 req held %0d", k), req1, t3[k]);
    end
    wait_idle(1'b1, "t3 idle");
    chk("t3 final req", req1, 1'b1);
    chk("t3 final data", data_o1, 8'h30);

    // 4: back-to-back, REL pops directly
    valid0 = 1'b1; data_i0 = 8'h31; step();
    data_i0 = 8'h32; step();
    data_i0 = 8'h33; step();
    valid0 = 1'b0;
    wait_req(1'b0, 1'b1, "t4 req first");
    chk("t4 data first", data_o0, 8'h31);
    ack0 = 1'b1;
    wait_req(1'b0, 1'b0, "t4 req release");
    ack0 = 1'b0;
    step();
    chk("t4 req low +1", req0, 1'b0);
    step();
    chk("t4 req low +2", req0, 1'b0);
    chk("t4 busy", busy0, 1'b1);
    step();
    chk("t4 req rises in REL", req0, 1'b1);
    chk("t4 data second", data_o0, 8'h32);
    chk("t4 level", level0, 3'd1);
    deliver0(8'h32, "t4 w32");
    deliver0(8'h33, "t4 w33");
    wait_idle(1'b0, "t4 idle");

    // 5: write vs pop at full, then at level 2
    for (int i = 0; i < 5; i++) begin
      valid0 = 1'b1; data_i0 = 8'(8'h41 + i);
      step();
    end
    chk("t5 level full", level0, 3'd4);
    data_i0 = 8'h46;
    ack0 = 1'b1;
    wait_req(1'b0, 1'b0, "t5 req release");
    ack0 = 1'b0;
    step(); step();
    chk("t5 ready low before pop", ready0, 1'b0);
    step();
    chk("t5 pop without write", level0, 3'd3);
    chk("t5 data 42", data_o0, 8'h42);
    step();
    valid0 = 1'b0;
    chk("t5 write after pop", level0, 3'd4);
    ack_cycle0("t5 c43");
    chk("t5 level 3", level0, 3'd3);
    chk("t5 data 43", data_o0, 8'h43);
    ack_cycle0("t5 c44");
    chk("t5 level 2", level0, 3'd2);
    ack0 = 1'b1;
    wait_req(1'b0, 1'b0, "t5 req release 44");
    ack0 = 1'b0;
    step(); step();
    valid0 = 1'b1; data_i0 = 8'h47;
    step();
    valid0 = 1'b0;
    chk("t5 write+pop level", level0, 3'd2);
    chk("t5 data 45", data_o0, 8'h45);
    chk("t5 req 45", req0, 1'b1);
    deliver0(8'h45, "t5 w45");
    deliver0(8'h46, "t5 w46");
    deliver0(8'h47, "t5 w47");
    wait_idle(1'b0, "t5 idle");

    // 6: reset mid-transfer
    for (int i = 0; i < 4; i++) begin
      valid0 = 1'b1; data_i0 = 8'(8'h61 + i);
      step();
    end
    valid0 = 1'b0;
    chk("t6 queued", level0, 3'd3);
    chk("t6 in REQ", req0, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t6 rst req", req0, 1'b0);
    chk("t6 rst data_o", data_o0, 8'h00);
    chk("t6 rst level", level0, 3'd0);
    chk("t6 rst ready", ready0, 1'b1);
    step(); step();
    rstn = 1'b1;
    step();
    valid0 = 1'b1; data_i0 = 8'h77;
    step();
    valid0 = 1'b0;
    deliver0(8'h77, "t6 w77");
    wait_idle(1'b0, "t6 idle");
    chk("t6 level", level0, 3'd0);
    chk("t6 data kept", data_o0, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
